// File: rtl/ex_stage.sv
// MIPS execute stage: single-cycle ALU plus an iterative HI/LO multiply/divide unit.
// Optional build macro EX_OVERFLOW_TRAP_EN enables the signed add/sub overflow flag (ovf).
module ex_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] readData1,
  input  logic [WIDTH-1:0] readData2,
  input  logic [WIDTH-1:0] imm,
  input  logic             ALUSrc,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       funct,
  output logic             res_valid,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic [WIDTH-1:0] store_data,
  output logic             ovf,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // state | meaning
  // IDLE  | accepting instructions, single-cycle ops complete here
  // BUSY  | mul/div iterating one step per cycle, upstream stalled
  typedef enum logic {IDLE, BUSY} state_t;

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               res_valid_q, res_valid_d;
  logic [WIDTH-1:0]   alu_result_q, alu_result_d;
  logic               zero_q, zero_d;
  logic [WIDTH-1:0]   store_data_q, store_data_d;
  logic               ovf_q, ovf_d;

  logic [WIDTH-1:0]   op_b;
  logic               accept;
  logic               is_muldiv;
  logic [WIDTH-1:0]   sum, diff;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf;

  assign in_ready   = (state_q == IDLE);
  assign op_b       = ALUSrc ? imm : readData2;
  assign accept     = in_valid && in_ready && !flush;
  assign is_muldiv  = (ALUOp == 2'b10) && (funct[5:2] == 4'b0110);
  assign sum        = readData1 + op_b;
  assign diff       = readData1 - op_b;

  always_comb begin
    alu_res = '0;
    unique case (ALUOp)
      2'b01: alu_res = diff;
      2'b10: begin
        case (funct)
          6'h20, 6'h21: alu_res = sum;
          6'h22, 6'h23: alu_res = diff;
          6'h24:        alu_res = readData1 & op_b;
          6'h25:        alu_res = readData1 | op_b;
          6'h26:        alu_res = readData1 ^ op_b;
          6'h27:        alu_res = ~(readData1 | op_b);
          6'h2A:        alu_res = {{(WIDTH-1){1'b0}}, ($signed(readData1) < $signed(op_b))};
          6'h2B:        alu_res = {{(WIDTH-1){1'b0}}, (readData1 < op_b)};
          6'h10:        alu_res = hi_q;
          6'h12:        alu_res = lo_q;
          default:      alu_res = '0;
        endcase
      end
      default: alu_res = sum;
    endcase
  end

`ifdef EX_OVERFLOW_TRAP_EN
  logic add_ovf, sub_ovf;
  assign add_ovf = (readData1[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != readData1[WIDTH-1]);
  assign sub_ovf = (readData1[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != readData1[WIDTH-1]);
  always_comb begin
    alu_ovf = 1'b0;
    if (ALUOp == 2'b00)
      alu_ovf = add_ovf;
    else if (ALUOp == 2'b01)
      alu_ovf = sub_ovf;
    else if (ALUOp == 2'b10 && funct == 6'h20)
      alu_ovf = add_ovf;
    else if (ALUOp == 2'b10 && funct == 6'h22)
      alu_ovf = sub_ovf;
  end
`else
  assign alu_ovf = 1'b0;
`endif

  // Operand preparation: magnitudes for signed ops, raw dividend when dividing by zero.
  logic               sgn_op, a_neg, b_neg, div_by_zero;
  logic [WIDTH-1:0]   a_mag, b_mag;
  assign sgn_op      = !funct[0];
  assign a_neg       = sgn_op && readData1[WIDTH-1];
  assign b_neg       = sgn_op && op_b[WIDTH-1];
  assign a_mag       = a_neg ? (~readData1 + WIDTH'(1)) : readData1;
  assign b_mag       = b_neg ? (~op_b + WIDTH'(1)) : op_b;
  assign div_by_zero = funct[1] && (op_b == '0);

  // Shift-add multiply step: {acc_hi, acc_lo} holds partial product / remaining multiplier.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_hi_nx, mul_lo_nx;
  assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_hi_nx = mul_sum[WIDTH:1];
  assign mul_lo_nx = {mul_sum[0], acc_lo_q[WIDTH-1:1]};

  // Restoring divide step: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff, div_hi_nx, div_lo_nx;
  logic               div_ok;
  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_ok    = (div_shift >= {1'b0, opnd_q});
  assign div_diff  = div_shift[WIDTH-1:0] - opnd_q;
  assign div_hi_nx = div_ok ? div_diff : div_shift[WIDTH-1:0];
  assign div_lo_nx = {acc_lo_q[WIDTH-2:0], div_ok};

  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  assign prod_raw = {mul_hi_nx, mul_lo_nx};
  assign prod_fix = neg_lo_q ? (~prod_raw + (2*WIDTH)'(1)) : prod_raw;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_hi_d     = acc_hi_q;
    acc_lo_d     = acc_lo_q;
    opnd_d       = opnd_q;
    is_div_d     = is_div_q;
    neg_lo_d     = neg_lo_q;
    neg_hi_d     = neg_hi_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    res_valid_d  = 1'b0;
    alu_result_d = alu_result_q;
    zero_d       = zero_q;
    store_data_d = store_data_q;
    ovf_d        = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          store_data_d = readData2;
          if (is_muldiv) begin
            state_d  = BUSY;
            cnt_d    = CNT_W'(WIDTH-1);
            is_div_d = funct[1];
            acc_hi_d = '0;
            if (funct[1]) begin
              acc_lo_d = div_by_zero ? readData1 : a_mag;
              opnd_d   = b_mag;
              neg_lo_d = !div_by_zero && (a_neg ^ b_neg);
              neg_hi_d = !div_by_zero && a_neg;
            end else begin
              acc_lo_d = b_mag;
              opnd_d   = a_mag;
              neg_lo_d = a_neg ^ b_neg;
              neg_hi_d = 1'b0;
            end
          end else begin
            res_valid_d  = 1'b1;
            alu_result_d = alu_res;
            zero_d       = (alu_res == '0);
            ovf_d        = alu_ovf;
          end
        end
      end
      BUSY: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_hi_d = is_div_q ? div_hi_nx : mul_hi_nx;
          acc_lo_d = is_div_q ? div_lo_nx : mul_lo_nx;
          if (cnt_q == '0) begin
            state_d      = IDLE;
            res_valid_d  = 1'b1;
            alu_result_d = '0;
            zero_d       = 1'b1;
            ovf_d        = 1'b0;
            if (is_div_q) begin
              lo_d = neg_lo_q ? (~div_lo_nx + WIDTH'(1)) : div_lo_nx;
              hi_d = neg_hi_q ? (~div_hi_nx + WIDTH'(1)) : div_hi_nx;
            end else begin
              {hi_d, lo_d} = prod_fix;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      acc_hi_q     <= '0;
      acc_lo_q     <= '0;
      opnd_q       <= '0;
      is_div_q     <= 1'b0;
      neg_lo_q     <= 1'b0;
      neg_hi_q     <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
      res_valid_q  <= 1'b0;
      alu_result_q <= '0;
      zero_q       <= 1'b0;
      store_data_q <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_hi_q     <= acc_hi_d;
      acc_lo_q     <= acc_lo_d;
      opnd_q       <= opnd_d;
      is_div_q     <= is_div_d;
      neg_lo_q     <= neg_lo_d;
      neg_hi_q     <= neg_hi_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      res_valid_q  <= res_valid_d;
      alu_result_q <= alu_result_d;
      zero_q       <= zero_d;
      store_data_q <= store_data_d;
      ovf_q        <= ovf_d;
    end
  end

  assign res_valid  = res_valid_q;
  assign alu_result = alu_result_q;
  assign zero       = zero_q;
  assign store_data = store_data_q;
  assign ovf        = ovf_q;
  assign hi         = hi_q;
  assign lo         = lo_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage: ALU ops, mul/div results and latency, flush and reset.
module tb_ex_stage;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] readData1 = '0;
  logic [W-1:0] readData2 = '0;
  logic [W-1:0] imm = '0;
  logic         ALUSrc = 1'b0;
  logic [1:0]   ALUOp = 2'b00;
  logic [5:0]   funct = 6'h00;
  logic         res_valid;
  logic [W-1:0] alu_result;
  logic         zero;
  logic [W-1:0] store_data;
  logic         ovf;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int errors = 0;
`ifdef EX_OVERFLOW_TRAP_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  ex_stage #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .readData1(readData1), .readData2(readData2), .imm(imm), .ALUSrc(ALUSrc),
    .ALUOp(ALUOp), .funct(funct), .res_valid(res_valid), .alu_result(alu_result),
    .zero(zero), .store_data(store_data), .ovf(ovf), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [5:0] fn, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic src, input logic [W-1:0] im);
    @(negedge clk);
    ALUOp = op; funct = fn; readData1 = a; readData2 = b; ALUSrc = src; imm = im;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  int n;
  int pulses;

  initial begin
    #12;
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_alu_result", 64'(alu_result), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_zero_ovf_sd", {zero, ovf, store_data}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(2'b10, 6'h20, 32'd5, 32'd7, 1'b0, 32'd0);
    chk("add_valid", 64'(res_valid), 64'd1);
    chk("add_result", 64'(alu_result), 64'd12);
    chk("add_zero", 64'(zero), 64'd0);
    chk("add_in_ready", 64'(in_ready), 64'd1);
    chk("add_store_data", 64'(store_data), 64'd7);
    @(negedge clk);
    chk("idle_no_valid", 64'(res_valid), 64'd0);

    issue(2'b01, 6'h00, 32'h1234, 32'h1234, 1'b0, 32'd0);
    chk("sub_result", 64'(alu_result), 64'd0);
    chk("sub_zero", 64'(zero), 64'd1);
    issue(2'b00, 6'h00, 32'h100, 32'd0, 1'b1, 32'hFFFF_FFFC);
    chk("addi_result", 64'(alu_result), 64'hFC);
    chk("addi_zero", 64'(zero), 64'd0);
    issue(2'b11, 6'h00, 32'd3, 32'd4, 1'b0, 32'd0);
    chk("aluop11_add", 64'(alu_result), 64'd7);

    issue(2'b10, 6'h24, 32'hF0F0_1234, 32'h0FF0_00FF, 1'b0, 32'd0);
    chk("and", 64'(alu_result), 64'h00F0_0034);
    issue(2'b10, 6'h25, 32'hF0F0_1234, 32'h0FF0_00FF, 1'b0, 32'd0);
    chk("or", 64'(alu_result), 64'hFFF0_12FF);
    issue(2'b10, 6'h26, 32'hF0F0_1234, 32'h0FF0_00FF, 1'b0, 32'd0);
    chk("xor", 64'(alu_result), 64'hFF00_12CB);
    issue(2'b10, 6'h27, 32'hF0F0_1234, 32'h0FF0_00FF, 1'b0, 32'd0);
    chk("nor", 64'(alu_result), 64'h000F_ED00);
    issue(2'b10, 6'h2A, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0);
    chk("slt", 64'(alu_result), 64'd1);
    issue(2'b10, 6'h2B, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0);
    chk("sltu", 64'(alu_result), 64'd0);
    issue(2'b10, 6'h3F, 32'd9, 32'd9, 1'b0, 32'd0);
    chk("unk_valid", 64'(res_valid), 64'd1);
    chk("unk_result", 64'(alu_result), 64'd0);

    // flush on the same edge as a mult: nothing accepted
    @(negedge clk);
    ALUOp = 2'b10; funct = 6'h18; readData1 = 32'd3; readData2 = 32'd3; ALUSrc = 1'b0;
    in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_accept_valid", 64'(res_valid), 64'd0);
    chk("flush_accept_ready", 64'(in_ready), 64'd1);

    issue(2'b10, 6'h18, 32'hFFFF_FFFE, 32'd3, 1'b0, 32'd0);
    chk("mult_busy", 64'(in_ready), 64'd0);
    wait_done(n);
    chk("mult_latency", 64'(n), 64'd32);
    chk("mult_ready", 64'(in_ready), 64'd1);
    chk("mult_alu_zero", 64'(alu_result), 64'd0);
    chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    issue(2'b10, 6'h10, 32'd0, 32'd0, 1'b0, 32'd0);
    chk("mfhi", 64'(alu_result), 64'hFFFF_FFFF);
    issue(2'b10, 6'h12, 32'd0, 32'd0, 1'b0, 32'd0);
    chk("mflo", 64'(alu_result), 64'hFFFF_FFFA);

    issue(2'b10, 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0);
    wait_done(n);
    chk("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    issue(2'b10, 6'h1A, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'd0);
    wait_done(n);
    chk("div_latency", 64'(n), 64'd32);
    chk("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(2'b10, 6'h1B, 32'd100, 32'd7, 1'b0, 32'd0);
    wait_done(n);
    chk("divu_hilo", {hi, lo}, 64'h0000_0002_0000_000E);
    issue(2'b10, 6'h1B, 32'd9, 32'd0, 1'b0, 32'd0);
    wait_done(n);
    chk("divu0_latency", 64'(n), 64'd32);
    chk("divu0_hilo", {hi, lo}, 64'h0000_0009_FFFF_FFFF);

    // flush in the 10th busy cycle
    issue(2'b10, 6'h1B, 32'd100, 32'd7, 1'b0, 32'd0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("busy_flush_ready", 64'(in_ready), 64'd1);
    chk("busy_flush_valid", 64'(res_valid), 64'd0);
    chk("busy_flush_hilo", {hi, lo}, 64'h0000_0009_FFFF_FFFF);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (res_valid) pulses++;
    end
    chk("busy_flush_no_pulse", 64'(pulses), 64'd0);

    issue(2'b10, 6'h18, 32'd3, 32'd5, 1'b0, 32'd0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_hilo", {hi, lo}, 64'd0);
    chk("rst_mid_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    issue(2'b10, 6'h18, 32'd3, 32'd5, 1'b0, 32'd0);
    wait_done(n);
    chk("mult_after_rst", {hi, lo}, 64'd15);

    issue(2'b10, 6'h20, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'd0);
    chk("add_ovf_result", 64'(alu_result), 64'h8000_0000);
    chk("add_ovf", 64'(ovf), 64'(OVF_EXP));
    issue(2'b10, 6'h21, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'd0);
    chk("addu_ovf", 64'(ovf), 64'd0);
    issue(2'b01, 6'h00, 32'h8000_0000, 32'd1, 1'b0, 32'd0);
    chk("sub_ovf_result", 64'(alu_result), 64'h7FFF_FFFF);
    chk("sub_ovf", 64'(ovf), 64'(OVF_EXP));
    issue(2'b10, 6'h23, 32'h8000_0000, 32'd1, 1'b0, 32'd0);
    chk("subu_ovf", 64'(ovf), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
